// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: instruction layout,
// legal function codes and the controller state encoding.
package alu_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_CMP  = 6'b111110;

  // Field order fixes the slice positions: op[31:26] rs[25:21] rt[20:16]
  // rd[15:11] shamt[10:6] funct[5:0].
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } inst_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic is_legal(input inst_t w);
    logic fn_ok;
    case (w.funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_MOVZ, FN_SLL, FN_CMP: fn_ok = 1'b1;
      default: fn_ok = 1'b0;
    endcase
    return fn_ok && (w.op == OP_RTYPE);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// 32-entry architectural register file: two operand read ports, one debug
// read port, one synchronous write port. R[0] is never written.
module reg_file
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREG];

  // NOTE: the array is reset explicitly because the architecture requires
  // every register to read zero after reset; that rules out a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the combinational ALU: accepts R-type
// words, fetches operands, captures the ALU result and commits it to rd.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_valid,
  input  logic [31:0]   inst,
  output logic          inst_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alu_card,
  output logic [4:0]    alu_shft,
  input  logic [DW-1:0] alu_f,
  output logic          wb_valid,
  output logic [4:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          illegal,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state_q, state_d;
  inst_t         ir_q;
  logic          commit_q;
  logic          reject_q;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          accept;

  assign inst_ready = (state_q == ST_IDLE);
  assign accept     = inst_valid && inst_ready;

  // wb_valid is high only during WB, so it doubles as the write enable.
  reg_file #(.DW(DW)) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (ir_q.rs),
    .ra_data  (rs_data),
    .rb_addr  (ir_q.rt),
    .rb_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Rejected words still pass through EXEC as a bubble so that both
  // outcomes report in the same cycle and issue spacing stays uniform.
  // NOTE: state_d is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      commit_q <= 1'b0;
      reject_q <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_card <= '0;
      alu_shft <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) ir_q <= inst_t'(inst);
        ST_DECODE: begin
          if (is_legal(ir_q)) begin
            alu_a    <= rs_data;
            alu_b    <= rt_data;
            alu_card <= ir_q.funct;
            alu_shft <= ir_q.shamt;
            // MOVZ condition is judged on the operand read here, not later.
            commit_q <= !((ir_q.funct == FN_MOVZ) && (rt_data != '0));
            reject_q <= 1'b0;
          end else begin
            commit_q <= 1'b0;
            reject_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (commit_q) begin
            wb_valid <= 1'b1;
            wb_addr  <= ir_q.rd;
            wb_data  <= alu_f;
          end
          illegal <= reject_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench plays the role of the ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [5:0]  alu_card;
  logic [4:0]  alu_shft;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  // ALU model; the override lets the bench load arbitrary register values.
  logic        ovr_en;
  logic [31:0] ovr_val;

  // Observations captured by run_inst.
  logic        obs_early, obs_v, obs_il, obs_rdy_wb, obs_rdy_after;
  logic [4:0]  obs_a, obs_shft;
  logic [31:0] obs_d, obs_dbg_wb, obs_dbg_after;

  alu_issue_ctrl #(.DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_card   (alu_card),
    .alu_shft   (alu_shft),
    .alu_f      (alu_f),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_f = '0;
    if (ovr_en) alu_f = ovr_val;
    else begin
      case (alu_card)
        6'h20:   alu_f = alu_a + alu_b;
        6'h22:   alu_f = alu_a - alu_b;
        6'h24:   alu_f = alu_a & alu_b;
        6'h25:   alu_f = alu_a | alu_b;
        6'h26:   alu_f = alu_a ^ alu_b;
        6'h0A:   alu_f = alu_a;
        6'h00:   alu_f = alu_b << alu_shft;
        6'h3E:   alu_f = {26'd0, alu_a == alu_b, alu_a != alu_b,
                          $signed(alu_a) < $signed(alu_b), $signed(alu_a) > $signed(alu_b),
                          alu_a < alu_b, alu_a > alu_b};
        default: alu_f = 32'hDEAD_BEEF;
      endcase
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Issue one word and sample the four following cycles (DECODE, EXEC, WB, IDLE).
  task automatic run_inst(input logic [31:0] w);
    @(negedge clk);
    inst = w; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0; inst = '0;
    obs_early = wb_valid | illegal;
    @(negedge clk);
    obs_early = obs_early | wb_valid | illegal;
    obs_shft = alu_shft;
    @(negedge clk);
    obs_v = wb_valid; obs_il = illegal; obs_a = wb_addr; obs_d = wb_data;
    obs_rdy_wb = inst_ready; obs_dbg_wb = dbg_data;
    @(negedge clk);
    obs_rdy_after = inst_ready; obs_dbg_after = dbg_data;
  endtask

  task automatic rd_reg(input logic [4:0] idx, output logic [31:0] val);
    @(negedge clk);
    dbg_addr = idx;
    #1 val = dbg_data;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    ovr_en = 1'b1; ovr_val = val;
    run_inst(enc(6'd0, 5'd0, 5'd0, idx, 5'd0, 6'h20));
    ovr_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_ready !== 1'b1 || wb_valid !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b wb_valid=%b illegal=%b, want 1/0/0", inst_ready, wb_valid, illegal);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_card !== 6'd0 || alu_shft !== 5'd0 ||
        wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h card=%h shft=%h addr=%h data=%h, want all 0",
               alu_a, alu_b, alu_card, alu_shft, wb_addr, wb_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_reg(5'd5, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_reg: R5=%h, want 0", v); end
  endtask

  task automatic test_add;
    logic [31:0] v;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    dbg_addr = 5'd3;
    run_inst(32'h0022_1820);
    checks++;
    if (obs_early !== 1'b0 || obs_v !== 1'b1 || obs_il !== 1'b0) begin
      errors++;
      $display("FAIL add_latency: early=%b wb_valid@3=%b illegal=%b, want 0/1/0", obs_early, obs_v, obs_il);
    end
    checks++;
    if (obs_a !== 5'd3 || obs_d !== 32'd8) begin
      errors++;
      $display("FAIL add_result: addr=%0d data=%h, want 3/00000008", obs_a, obs_d);
    end
    checks++;
    if (obs_rdy_wb !== 1'b0 || obs_rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL add_ready: ready in WB=%b after=%b, want 0/1", obs_rdy_wb, obs_rdy_after);
    end
    checks++;
    if (obs_dbg_wb !== 32'd0 || obs_dbg_after !== 32'd8) begin
      errors++;
      $display("FAIL add_dbg_bypass: dbg in WB=%h after=%h, want 0/8", obs_dbg_wb, obs_dbg_after);
    end
    rd_reg(5'd3, v);
    checks++;
    if (v !== 32'd8) begin errors++; $display("FAIL add_reg: R3=%h, want 8", v); end
  endtask

  task automatic test_sub;
    logic [31:0] v;
    run_inst(enc(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h22));
    checks++;
    if (obs_v !== 1'b1 || obs_a !== 5'd4 || obs_d !== 32'd2) begin
      errors++;
      $display("FAIL sub_pos: valid=%b addr=%0d data=%h, want 1/4/00000002", obs_v, obs_a, obs_d);
    end
    run_inst(enc(6'd0, 5'd2, 5'd1, 5'd4, 5'd0, 6'h22));
    checks++;
    if (obs_v !== 1'b1 || obs_d !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sub_neg: valid=%b data=%h, want 1/fffffffe", obs_v, obs_d);
    end
    rd_reg(5'd4, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_reg: R4=%h, want fffffffe", v); end
  endtask

  task automatic test_sll;
    preload(5'd2, 32'd1);
    run_inst(enc(6'd0, 5'd0, 5'd2, 5'd5, 5'd4, 6'h00));
    checks++;
    if (obs_shft !== 5'd4) begin errors++; $display("FAIL sll_shamt: alu_shft in EXEC=%0d, want 4", obs_shft); end
    checks++;
    if (obs_v !== 1'b1 || obs_a !== 5'd5 || obs_d !== 32'h10) begin
      errors++;
      $display("FAIL sll_result: valid=%b addr=%0d data=%h, want 1/5/00000010", obs_v, obs_a, obs_d);
    end
  endtask

  task automatic test_movz;
    logic [31:0] v;
    run_inst(enc(6'd0, 5'd1, 5'd0, 5'd6, 5'd0, 6'h0A));
    checks++;
    if (obs_v !== 1'b1 || obs_a !== 5'd6 || obs_d !== 32'd5) begin
      errors++;
      $display("FAIL movz_taken: valid=%b addr=%0d data=%h, want 1/6/00000005", obs_v, obs_a, obs_d);
    end
    // rs=R3 (8) so a wrongful commit would be visible in R6.
    run_inst(enc(6'd0, 5'd3, 5'd2, 5'd6, 5'd0, 6'h0A));
    checks++;
    if (obs_v !== 1'b0 || obs_il !== 1'b0) begin
      errors++;
      $display("FAIL movz_skip: wb_valid=%b illegal=%b, want 0/0", obs_v, obs_il);
    end
    rd_reg(5'd6, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL movz_reg: R6=%h, want 5", v); end
  endtask

  task automatic test_cmp;
    // R1=5, R2=1: ne, sgt, ugt set -> 6'b010101.
    run_inst(enc(6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h3E));
    checks++;
    if (obs_v !== 1'b1 || obs_a !== 5'd7 || obs_d !== 32'h15) begin
      errors++;
      $display("FAIL cmp_flags: valid=%b addr=%0d data=%h, want 1/7/00000015", obs_v, obs_a, obs_d);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] v;
    logic [31:0] words [2];
    words[0] = enc(6'b000010, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20);
    words[1] = enc(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h3F);
    for (int k = 0; k < 2; k++) begin
      run_inst(words[k]);
      checks++;
      if (obs_early !== 1'b0 || obs_il !== 1'b1 || obs_v !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse[%0d]: early=%b illegal@3=%b wb_valid=%b, want 0/1/0", k, obs_early, obs_il, obs_v);
      end
      checks++;
      if (obs_rdy_after !== 1'b1 || obs_a !== 5'd7 || obs_d !== 32'h15) begin
        errors++;
        $display("FAIL illegal_hold[%0d]: ready=%b addr=%0d data=%h, want 1/7/00000015", k, obs_rdy_after, obs_a, obs_d);
      end
    end
    rd_reg(5'd8, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL illegal_reg: R8=%h, want 0", v); end
  endtask

  task automatic test_rd0;
    logic [31:0] v;
    run_inst(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20));
    checks++;
    if (obs_v !== 1'b1 || obs_a !== 5'd0 || obs_d !== 32'd6) begin
      errors++;
      $display("FAIL rd0_pulse: valid=%b addr=%0d data=%h, want 1/0/00000006", obs_v, obs_a, obs_d);
    end
    rd_reg(5'd0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL rd0_reg: R0=%h, want 0", v); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] mask;
    mask = '0;
    @(negedge clk);
    inst = enc(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20); inst_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) inst_valid = 1'b0;
      mask[k] = wb_valid;
    end
    checks++;
    if (mask !== 9'h088) begin
      errors++;
      $display("FAIL back_to_back: wb_valid cycle mask=%b, want 010001000", mask);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v1, v9;
    logic seen;
    @(negedge clk);
    inst = enc(6'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'h20); inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_ready !== 1'b1 || alu_a !== 32'd0 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b alu_a=%h wb_data=%h, want 1/0/0", inst_ready, alu_a, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | wb_valid | illegal;
    end
    checks++;
    if (seen !== 1'b0 || inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_abort: pulse seen=%b ready=%b, want 0/1", seen, inst_ready);
    end
    rd_reg(5'd1, v1);
    rd_reg(5'd9, v9);
    checks++;
    if (v1 !== 32'd0 || v9 !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_regs: R1=%h R9=%h, want 0/0", v1, v9);
    end
  endtask

  initial begin
    rst_n = 1'b0; inst_valid = 1'b0; inst = '0; dbg_addr = '0;
    ovr_en = 1'b0; ovr_val = '0;
    test_reset();
    test_add();
    test_sub();
    test_sll();
    test_movz();
    test_cmp();
    test_illegal();
    test_rd0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
